// File: rtl/fa_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : fa_vector_checker
//  Description : Exhaustive in-hardware tester for 1-bit full adders. Walks
//                all eight {a,b,c} vectors to NUM_DUT adders in parallel and
//                compares each adder's sum/carry against the golden result.
//                It reports a sticky per-DUT fail mask, a saturating mismatch
//                count and the first failing vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module fa_vector_checker #(
    parameter int NUM_DUT = 3,
    parameter int SETTLE  = 1,
    parameter int ERR_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               a,
    output logic               b,
    output logic               c,
    input  logic [NUM_DUT-1:0] sum_in,
    input  logic [NUM_DUT-1:0] carry_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_DUT-1:0] fail_mask,
    output logic [ERR_W-1:0]   err_count,
    output logic [2:0]         first_fail_vec,
    output logic               first_fail_valid
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_APPLY = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Settle counter only has to reach SETTLE-1; keep it at least one bit wide.
    localparam int                 c_CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [ERR_W-1:0]   c_ERR_MAX     = '1;
    localparam logic [ERR_W-1:0]   c_ERR_ONE     = ERR_W'(1);
    localparam logic [2:0]         c_VEC_LAST    = 3'd7;

    logic [1:0]         r_state_q;
    logic [1:0]         w_state_d;
    logic [2:0]         r_vec_q;
    logic [2:0]         w_vec_d;
    logic [c_CNT_W-1:0] r_settle_q;
    logic [c_CNT_W-1:0] w_settle_d;
    logic [NUM_DUT-1:0] r_fail_mask_q;
    logic [NUM_DUT-1:0] w_fail_mask_d;
    logic [ERR_W-1:0]   r_err_count_q;
    logic [ERR_W-1:0]   w_err_count_d;
    logic [2:0]         r_ffv_q;
    logic [2:0]         w_ffv_d;
    logic               r_ffv_valid_q;
    logic               w_ffv_valid_d;

    logic               w_start_ok;
    logic               w_settled;
    logic               w_exp_sum;
    logic               w_exp_carry;
    logic [NUM_DUT-1:0] w_mis;

    // A start request only counts while no run is in flight.
    assign w_start_ok = start && ((r_state_q == c_IDLE) || (r_state_q == c_DONE));
    assign w_settled  = (r_settle_q == c_SETTLE_LAST);

    // Golden full-adder result for the vector currently on {a,b,c}.
    assign w_exp_sum   = ^r_vec_q;
    assign w_exp_carry = (r_vec_q[2] & r_vec_q[1]) | (r_vec_q[2] & r_vec_q[0])
                       | (r_vec_q[1] & r_vec_q[0]);

    // Per-DUT mismatch: either output disagreeing marks the DUT for this vector.
    assign w_mis = (sum_in   ^ {NUM_DUT{w_exp_sum}})
                 | (carry_in ^ {NUM_DUT{w_exp_carry}});

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic: APPLY holds SETTLE cycles, CHECK is one cycle per vector.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE:  if (w_start_ok) w_state_d = c_APPLY;
            c_APPLY: if (w_settled)  w_state_d = c_CHECK;
            c_CHECK: w_state_d = (r_vec_q == c_VEC_LAST) ? c_DONE : c_APPLY;
            c_DONE:  if (w_start_ok) w_state_d = c_APPLY;
            default: w_state_d = c_IDLE;
        endcase
    end

    // Output decode: stimulus is only driven while a run is active.
    always_comb begin
        a    = 1'b0;
        b    = 1'b0;
        c    = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (r_state_q)
            c_APPLY, c_CHECK: begin
                {a, b, c} = r_vec_q;
                busy      = 1'b1;
            end
            c_DONE: begin
                done = 1'b1;
                pass = (r_fail_mask_q == '0);
            end
            default: ;
        endcase
    end

    // Datapath next values: vector walk, settle timing and result accumulation.
    always_comb begin
        w_vec_d       = r_vec_q;
        w_settle_d    = r_settle_q;
        w_fail_mask_d = r_fail_mask_q;
        w_err_count_d = r_err_count_q;
        w_ffv_d       = r_ffv_q;
        w_ffv_valid_d = r_ffv_valid_q;
        case (r_state_q)
            c_IDLE, c_DONE: begin
                if (w_start_ok) begin
                    w_vec_d       = 3'd0;
                    w_settle_d    = '0;
                    w_fail_mask_d = '0;
                    w_err_count_d = '0;
                    w_ffv_d       = 3'd0;
                    w_ffv_valid_d = 1'b0;
                end
            end
            c_APPLY: begin
                w_settle_d = w_settled ? '0 : (r_settle_q + c_CNT_ONE);
            end
            c_CHECK: begin
                w_fail_mask_d = r_fail_mask_q | w_mis;
                // Add one per mismatching DUT, pinning at the all-ones value.
                for (int i = 0; i < NUM_DUT; i++) begin
                    if (w_mis[i] && (w_err_count_d != c_ERR_MAX)) begin
                        w_err_count_d = w_err_count_d + c_ERR_ONE;
                    end
                end
                if ((w_mis != '0) && !r_ffv_valid_q) begin
                    w_ffv_d       = r_vec_q;
                    w_ffv_valid_d = 1'b1;
                end
                // Vector 7 stays put; DONE blanks the stimulus anyway.
                if (r_vec_q != c_VEC_LAST) begin
                    w_vec_d = r_vec_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers, cleared by reset together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_q       <= 3'd0;
            r_settle_q    <= '0;
            r_fail_mask_q <= '0;
            r_err_count_q <= '0;
            r_ffv_q       <= 3'd0;
            r_ffv_valid_q <= 1'b0;
        end else begin
            r_vec_q       <= w_vec_d;
            r_settle_q    <= w_settle_d;
            r_fail_mask_q <= w_fail_mask_d;
            r_err_count_q <= w_err_count_d;
            r_ffv_q       <= w_ffv_d;
            r_ffv_valid_q <= w_ffv_valid_d;
        end
    end

    assign fail_mask        = r_fail_mask_q;
    assign err_count        = r_err_count_q;
    assign first_fail_vec   = r_ffv_q;
    assign first_fail_valid = r_ffv_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fa_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fa_vector_checker
//  Description : Self-checking bench for fa_vector_checker. Three checker
//                instances (SETTLE=1/ERR_W=4, SETTLE=3/ERR_W=4,
//                SETTLE=1/ERR_W=3) each drive three behavioural full adders
//                with selectable faults, compared every cycle against a
//                run-level model of the checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fa_vector_checker;

    localparam int NCFG = 3;

    logic       clk;
    logic       rst_s     [NCFG];
    logic       start_s   [NCFG];
    logic       busy_s    [NCFG];
    logic       done_s    [NCFG];
    logic       pass_s    [NCFG];
    logic       ffvv_s    [NCFG];
    logic [2:0] abc_s     [NCFG];
    logic [2:0] fm_s      [NCFG];
    logic [2:0] ffv_s     [NCFG];
    logic [3:0] ec_s      [NCFG];
    int         fault     [NCFG][3];

    int n_total = 0;
    int n_pass  = 0;

    // Fault codes: 0 none, 1 sum stuck-0, 2 sum stuck-1, 3 carry inverted,
    // 4 sum inverted, 5 carry stuck-0, 6 carry stuck-1.
    // Golden {carry,sum} is just the 2-bit count of ones in the vector.
    function automatic logic [1:0] golden(input int v);
        return 2'(((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1));
    endfunction

    function automatic logic [1:0] faulty(input int ft, input int v);
        logic [1:0] r;
        r = golden(v);
        case (ft)
            1: r[0] = 1'b0;
            2: r[0] = 1'b1;
            3: r[1] = ~r[1];
            4: r[0] = ~r[0];
            5: r[1] = 1'b0;
            6: r[1] = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    // Expected results after the first n vectors have been checked.
    function automatic void model_results(input int ft [3], input int n, input int emax,
                                          output logic [2:0] m, output int cnt,
                                          output logic [2:0] fv, output logic fvv);
        int total;
        total = 0;
        m     = 3'd0;
        fv    = 3'd0;
        fvv   = 1'b0;
        for (int v = 0; v < n; v++) begin
            for (int i = 0; i < 3; i++) begin
                if (faulty(ft[i], v) != golden(v)) begin
                    m[i]  = 1'b1;
                    total = total + 1;
                    if (!fvv) begin
                        fv  = 3'(v);
                        fvv = 1'b1;
                    end
                end
            end
        end
        cnt = (total > emax) ? emax : total;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int settle_of(input int g);
        return (g == 1) ? 3 : 1;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int S = (g == 1) ? 3 : 1;
        localparam int E = (g == 2) ? 3 : 4;

        logic         a, b, c, busy, done, pass, ffvv;
        logic [2:0]   sum_in, carry_in, fail_mask, ffv;
        logic [E-1:0] err_count;

        fa_vector_checker #(.NUM_DUT(3), .SETTLE(S), .ERR_W(E)) u_dut (
            .clk              (clk),
            .rst              (rst_s[g]),
            .start            (start_s[g]),
            .a                (a),
            .b                (b),
            .c                (c),
            .sum_in           (sum_in),
            .carry_in         (carry_in),
            .busy             (busy),
            .done             (done),
            .pass             (pass),
            .fail_mask        (fail_mask),
            .err_count        (err_count),
            .first_fail_vec   (ffv),
            .first_fail_valid (ffvv)
        );

        // Behavioural adders under test, with per-DUT fault injection.
        always_comb begin
            sum_in   = 3'd0;
            carry_in = 3'd0;
            for (int i = 0; i < 3; i++) begin
                {carry_in[i], sum_in[i]} = faulty(fault[g][i], int'({a, b, c}));
            end
        end

        assign busy_s[g] = busy;
        assign done_s[g] = done;
        assign pass_s[g] = pass;
        assign ffvv_s[g] = ffvv;
        assign abc_s[g]  = {a, b, c};
        assign fm_s[g]   = fail_mask;
        assign ffv_s[g]  = ffv;
        assign ec_s[g]   = 4'(err_count);

        // Run-level model: idle / running since edge t0 / done.
        int ecount = 0;
        int t0     = 0;
        int mst    = 0;
        bit armed  = 1'b0;
        int mf [3] = '{0, 0, 0};

        always @(posedge clk) begin
            ecount <= ecount + 1;
            if (rst_s[g]) begin
                mst   <= 0;
                armed <= 1'b1;
            end else if (mst != 1 && start_s[g]) begin
                mst <= 1;
                t0  <= ecount + 1;
                for (int i = 0; i < 3; i++) mf[i] <= fault[g][i];
            end else if (mst == 1 && (ecount + 1 - t0) == 8 * (S + 1)) begin
                mst <= 2;
            end
        end

        // Every-cycle comparison of all outputs against the model.
        always @(negedge clk) begin
            int         el, nchk, xcnt;
            logic [2:0] xm, xv, xabc;
            logic       xvv;
            if (armed) begin
                el   = ecount - t0;
                nchk = 0;
                xabc = 3'd0;
                if (mst == 1) begin
                    nchk = el / (S + 1);
                    xabc = 3'(nchk);
                end else if (mst == 2) begin
                    nchk = 8;
                end
                model_results(mf, nchk, (1 << E) - 1, xm, xcnt, xv, xvv);
                chk($sformatf("cfg%0d abc", g),       int'({a, b, c}), int'(xabc));
                chk($sformatf("cfg%0d busy", g),      int'(busy),      int'(mst == 1));
                chk($sformatf("cfg%0d done", g),      int'(done),      int'(mst == 2));
                chk($sformatf("cfg%0d pass", g),      int'(pass),      int'(mst == 2 && xm == 3'd0));
                chk($sformatf("cfg%0d fail_mask", g), int'(fail_mask), int'(xm));
                chk($sformatf("cfg%0d err_count", g), int'(err_count), xcnt);
                chk($sformatf("cfg%0d ffv", g),       int'(ffv),       int'(xv));
                chk($sformatf("cfg%0d ffv_valid", g), int'(ffvv),      int'(xvv));
            end
        end
    end

    // Pulse start, optionally hammer start while busy, and measure edges to done.
    task automatic run(input int g, input bit repulse, output int edges);
        int lim;
        lim = 8 * (settle_of(g) + 1) + 4;
        @(negedge clk);
        start_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b0;
        edges = 0;
        while (!done_s[g] && edges < lim) begin
            if (repulse) start_s[g] = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            edges++;
        end
        start_s[g] = 1'b0;
    endtask

    task automatic set_faults(input int g, input int f0, input int f1, input int f2);
        fault[g][0] = f0;
        fault[g][1] = f1;
        fault[g][2] = f2;
    endtask

    initial begin
        int edges;
        for (int g = 0; g < NCFG; g++) begin
            rst_s[g]   = 1'b1;
            start_s[g] = 1'b0;
            set_faults(g, 0, 0, 0);
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NCFG; g++) rst_s[g] = 1'b0;

        // Reset state.
        chk("reset done", int'(done_s[0]), 0);
        chk("reset busy", int'(busy_s[0]), 0);
        chk("reset err_count", int'(ec_s[0]), 0);

        // T1: three good adders.
        run(0, 1'b0, edges);
        chk("T1 latency", edges, 16);
        chk("T1 pass", int'(pass_s[0]), 1);
        chk("T1 fail_mask", int'(fm_s[0]), 0);
        chk("T1 ffv_valid", int'(ffvv_s[0]), 0);

        // T2: DUT1 sum stuck-0 (started from DONE).
        set_faults(0, 0, 1, 0);
        run(0, 1'b0, edges);
        chk("T2 fail_mask", int'(fm_s[0]), 3'b010);
        chk("T2 err_count", int'(ec_s[0]), 4);
        chk("T2 ffv", int'(ffv_s[0]), 1);
        chk("T2 pass", int'(pass_s[0]), 0);

        // T3: DUT1 sum stuck-0 plus DUT2 carry inverted, then 3-bit counter.
        set_faults(0, 0, 1, 3);
        run(0, 1'b0, edges);
        chk("T3 fail_mask", int'(fm_s[0]), 3'b110);
        chk("T3 err_count", int'(ec_s[0]), 12);
        chk("T3 ffv", int'(ffv_s[0]), 0);
        set_faults(2, 0, 1, 3);
        run(2, 1'b0, edges);
        chk("T3 err_count sat", int'(ec_s[2]), 7);

        // T4: start hammered while busy; fixed adders restarted from DONE.
        set_faults(0, 0, 0, 0);
        run(0, 1'b1, edges);
        chk("T4 latency", edges, 16);
        chk("T4 pass", int'(pass_s[0]), 1);
        chk("T4 err_count", int'(ec_s[0]), 0);

        // T5: reset at vector 4 with DUT0 sum inverted.
        set_faults(0, 4, 0, 0);
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("T5 vec before rst", int'(abc_s[0]), 3'b100);
        chk("T5 err before rst", int'(ec_s[0]), 4);
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        chk("T5 busy after rst", int'(busy_s[0]), 0);
        chk("T5 abc after rst", int'(abc_s[0]), 0);
        chk("T5 fail_mask after rst", int'(fm_s[0]), 0);
        chk("T5 ffv_valid after rst", int'(ffvv_s[0]), 0);
        set_faults(0, 0, 0, 0);
        run(0, 1'b0, edges);
        chk("T5 latency", edges, 16);
        chk("T5 pass", int'(pass_s[0]), 1);

        // T6: SETTLE=3 instance.
        run(1, 1'b0, edges);
        chk("T6 latency", edges, 32);
        set_faults(1, 6, 0, 0);
        run(1, 1'b1, edges);
        chk("T6 fail_mask", int'(fm_s[1]), 3'b001);
        chk("T6 err_count", int'(ec_s[1]), 4);

        // Randomized runs: random instance, faults, start hammering, aborts.
        for (int r = 0; r < 30; r++) begin
            int g;
            int cyc;
            g = $urandom_range(0, NCFG - 1);
            for (int i = 0; i < 3; i++)
                fault[g][i] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
            if ($urandom_range(0, 4) == 0) begin
                cyc = $urandom_range(0, 8 * (settle_of(g) + 1) - 1);
                @(negedge clk);
                start_s[g] = 1'b1;
                @(negedge clk);
                start_s[g] = 1'b0;
                repeat (cyc) @(negedge clk);
                rst_s[g] = 1'b1;
                @(negedge clk);
                rst_s[g] = 1'b0;
                chk("rand abort busy", int'(busy_s[g]), 0);
            end else begin
                run(g, $urandom_range(0, 1) == 1, edges);
                chk("rand latency", edges, 8 * (settle_of(g) + 1));
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
